// File: rtl/seq_det_rr_sched.sv
// Round-robin scheduler sharing one non-overlapping "1001" detector among N_CH serial channels.
// Each channel keeps its own 2-bit detector state; one granted bit is processed per clock.
module seq_det_rr_sched #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] bit_in,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] gnt,
  output logic            det,
  output logic [CH_W-1:0] det_ch,
  output logic [7:0]      det_cnt
);

  localparam logic [1:0] S0 = 2'd0;  // idle
  localparam logic [1:0] S1 = 2'd1;  // seen "1"
  localparam logic [1:0] S2 = 2'd2;  // seen "10"
  localparam logic [1:0] S3 = 2'd3;  // seen "100"

  logic [1:0]      r_st [N_CH];
  logic [CH_W-1:0] r_ptr;
  logic            r_det;
  logic [CH_W-1:0] r_det_ch;
  logic [7:0]      r_det_cnt;

  logic            w_any;
  logic [CH_W-1:0] w_cand;
  logic [CH_W-1:0] w_idx;
  logic [CH_W-1:0] w_ptr_nxt;
  logic [N_CH-1:0] w_gnt;
  logic [1:0]      w_st_cur;
  logic [1:0]      w_st_nxt;
  logic            w_bit;
  logic            w_hit;

  // Search ptr, ptr+1, ... mod N_CH; first requester wins. Reset masks every grant.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    w_any  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    w_gnt  = '0;
    for (int j = 0; j < N_CH; j++) begin
      w_cand = CH_W'((int'(r_ptr) + j) % N_CH);
      if (!w_any && req[w_cand] && reset_n) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
    if (w_any) w_gnt[w_idx] = 1'b1;
  end

  assign w_ptr_nxt = (w_idx == CH_W'(N_CH - 1)) ? '0 : w_idx + CH_W'(1);

  assign w_st_cur = r_st[w_idx];
  assign w_bit    = bit_in[w_idx];

  always_comb begin
    w_st_nxt = S0;
    case (w_st_cur)
      S0:      w_st_nxt = w_bit ? S1 : S0;
      S1:      w_st_nxt = w_bit ? S1 : S2;
      S2:      w_st_nxt = w_bit ? S1 : S3;
      default: w_st_nxt = S0;  // S3 restarts on either bit: matching is non-overlapping
    endcase
  end

  // A clear on the granted channel swallows its bit, so it cannot complete a match.
  assign w_hit = w_any && (w_st_cur == S3) && w_bit && !clr[w_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the per-channel state array is a handful of flops that must start at S0, so it is reset like any register.
      for (int i = 0; i < N_CH; i++) r_st[i] <= S0;
      r_ptr     <= '0;
      r_det     <= 1'b0;
      r_det_ch  <= '0;
      r_det_cnt <= '0;
    end else begin
      r_det <= w_hit;
      if (w_any) begin
        r_ptr        <= w_ptr_nxt;
        r_st[w_idx]  <= w_st_nxt;
      end
      if (w_hit) begin
        r_det_ch <= w_idx;
        if (r_det_cnt != 8'hFF) r_det_cnt <= r_det_cnt + 8'd1;
      end
      // NOTE: non-blocking updates resolve last-write-wins, so this loop overrides the datapath write above.
      for (int i = 0; i < N_CH; i++) begin
        if (clr[i]) r_st[i] <= S0;
      end
    end
  end

  assign gnt     = w_gnt;
  assign det     = r_det;
  assign det_ch  = r_det_ch;
  assign det_cnt = r_det_cnt;

endmodule
